// File: rtl/conv_fc_bridge_v3.sv
// Ready/valid bridge from the conv/pool stage to the fc stage: registered input, FWFT FIFO, valid reorder, fc-layer reset sequencer.
// Optional popped-beat counter is enabled by defining CONV_FC_BRIDGE_PERF_EN.
module conv_fc_bridge_v3 #(
    parameter int BitSize      = 8,
    parameter int NumOfK       = 8,
    parameter int ProcElements = 2,
    parameter int FifoDepth    = 4,
    parameter int MaxNumNerves = 8,
    parameter int LatencyDelay = 3,
    parameter int ReverseValid = 1
) (
    input  logic                            clk,
    input  logic                            res,
    input  logic [NumOfK-1:0]               in_valid,
    input  logic [ProcElements*BitSize-1:0] in_data,
    input  logic                            in_set_done,
    input  logic                            out_ready,
    output logic [NumOfK-1:0]               out_valid,
    output logic [ProcElements*BitSize-1:0] out_data,
    output logic                            out_fl_res,
    output logic                            out_busy,
    output logic                            out_overflow,
    output logic [15:0]                     out_beat_count
);

    localparam int DW       = ProcElements * BitSize;
    localparam int PW       = $clog2(FifoDepth);
    localparam int OW       = PW + 1;
    localparam int CNT_LAST = NumOfK + MaxNumNerves + LatencyDelay - 1;
    localparam int CW       = $clog2(NumOfK + MaxNumNerves + LatencyDelay) + 1;

    typedef enum logic [1:0] {IDLE, DRAIN, COUNT, PULSE} state_t;

    function automatic logic [NumOfK-1:0] order_valid(input logic [NumOfK-1:0] v);
        logic [NumOfK-1:0] r;
        for (int i = 0; i < NumOfK; i++)
            r[i] = (ReverseValid != 0) ? v[NumOfK-1-i] : v[i];
        return r;
    endfunction

    // Stage p0: unconditional input capture, conv is never stalled
    logic [NumOfK-1:0] vld_p0;
    logic [DW-1:0]     data_p0;
    logic              set_done_p0;

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            vld_p0      <= '0;
            set_done_p0 <= 1'b0;
        end else begin
            vld_p0      <= in_valid;
            set_done_p0 <= in_set_done;
        end
    end

    always_ff @(posedge clk) begin
        data_p0 <= in_data;
    end

    // Stage p1: FWFT FIFO storage and occupancy
    logic [NumOfK-1:0] mem_v_p1 [FifoDepth];
    logic [DW-1:0]     mem_d_p1 [FifoDepth];
    logic [PW-1:0]     wr_ptr_p1, rd_ptr_p1;
    logic [OW-1:0]     occ_p1;
    logic              ovf_p1;
    logic              empty, full, push_req, push, pop, drop;

    assign empty    = (occ_p1 == '0);
    assign full     = (occ_p1 == OW'(FifoDepth));
    assign push_req = |vld_p0;
    assign pop      = out_ready & ~empty;
    assign push     = push_req & (~full | pop);
    assign drop     = push_req & full & ~pop;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_v_p1[wr_ptr_p1] <= order_valid(vld_p0);
            mem_d_p1[wr_ptr_p1] <= data_p0;
        end
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            wr_ptr_p1 <= '0;
            rd_ptr_p1 <= '0;
            occ_p1    <= '0;
            ovf_p1    <= 1'b0;
        end else begin
            if (push)
                wr_ptr_p1 <= wr_ptr_p1 + PW'(1);
            if (pop)
                rd_ptr_p1 <= rd_ptr_p1 + PW'(1);
            if (push && !pop)
                occ_p1 <= occ_p1 + OW'(1);
            else if (pop && !push)
                occ_p1 <= occ_p1 - OW'(1);
            if (drop)
                ovf_p1 <= 1'b1;
        end
    end

    always_comb begin
        out_valid = '0;
        out_data  = '0;
        if (!empty) begin
            out_valid = mem_v_p1[rd_ptr_p1];
            out_data  = mem_d_p1[rd_ptr_p1];
        end
    end

    // fc-layer reset sequencer; the count starts only once nothing is left in flight
    state_t        state, state_nxt;
    logic [CW-1:0] cnt;
    logic          pending;

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:  if (set_done_p0 || pending) state_nxt = DRAIN;
            DRAIN: if (empty && !push_req)     state_nxt = COUNT;
            COUNT: if (cnt == CW'(CNT_LAST))   state_nxt = PULSE;
            PULSE: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state   <= IDLE;
            cnt     <= '0;
            pending <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= (state == COUNT) ? cnt + CW'(1) : '0;
            if (state == IDLE && state_nxt == DRAIN)
                pending <= 1'b0;
            else if (set_done_p0 && state != IDLE)
                pending <= 1'b1;
        end
    end

    assign out_fl_res   = (state == PULSE);
    assign out_busy     = (state != IDLE) | ~empty | push_req;
    assign out_overflow = ovf_p1;

`ifdef CONV_FC_BRIDGE_PERF_EN
    function automatic logic [15:0] sat_inc16(input logic [15:0] c);
        return (c == 16'hFFFF) ? c : c + 16'd1;
    endfunction

    logic [15:0] beat_cnt_p1;

    always_ff @(posedge clk or posedge res) begin
        if (res)
            beat_cnt_p1 <= '0;
        else if (state == PULSE)
            beat_cnt_p1 <= '0;
        else if (pop)
            beat_cnt_p1 <= sat_inc16(beat_cnt_p1);
    end

    assign out_beat_count = beat_cnt_p1;
`else
    assign out_beat_count = 16'h0000;
`endif

endmodule

// File: tb/tb_conv_fc_bridge_v3.sv
// Scoreboard bench for conv_fc_bridge_v3: queue-based reference model, negedge monitor, directed and random stimulus.
module tb_conv_fc_bridge_v3;

    localparam int NK = 8;
    localparam int DW = 16;
    localparam int DEPTH = 4;
    localparam int PULSE_DLY = 19;
`ifdef CONV_FC_BRIDGE_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          res = 1'b1;
    logic [NK-1:0] in_valid = '0;
    logic [DW-1:0] in_data = '0;
    logic          in_set_done = 1'b0;
    logic          out_ready = 1'b0;
    logic [NK-1:0] out_valid;
    logic [DW-1:0] out_data;
    logic          out_fl_res, out_busy, out_overflow;
    logic [15:0]   out_beat_count;

    conv_fc_bridge_v3 dut (
        .clk(clk), .res(res), .in_valid(in_valid), .in_data(in_data),
        .in_set_done(in_set_done), .out_ready(out_ready), .out_valid(out_valid),
        .out_data(out_data), .out_fl_res(out_fl_res), .out_busy(out_busy),
        .out_overflow(out_overflow), .out_beat_count(out_beat_count)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [NK-1:0] v; logic [DW-1:0] d; } beat_t;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    beat_t         mq[$];
    logic [NK-1:0] m_sv;
    logic [DW-1:0] m_sd;
    logic          m_ssd;
    bit            m_ovf;
    int            m_phase;   // 0 idle, 1 draining, 2 counting, 3 pulse
    int            m_left;
    bit            m_pend;
    int            m_beats;

    function automatic logic [NK-1:0] rev(input logic [NK-1:0] v);
        return {<<{v}};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_clear();
        mq.delete();
        m_sv = '0; m_sd = '0; m_ssd = 1'b0;
        m_ovf = 0; m_phase = 0; m_left = 0; m_pend = 0; m_beats = 0;
    endtask

    task automatic model_step();
        bit pop, drain_ok;
        int ph;
        pop      = out_ready && (mq.size() > 0);
        drain_ok = (mq.size() == 0) && (m_sv == '0);
        ph       = m_phase;
        if (ph == 3) m_beats = 0;
        else if (pop && m_beats < 65535) m_beats++;
        case (ph)
            0: if (m_ssd || m_pend) begin m_phase = 1; m_pend = 0; end
            1: if (drain_ok) begin m_phase = 2; m_left = PULSE_DLY; end
            2: begin m_left--; if (m_left == 0) m_phase = 3; end
            default: m_phase = 0;
        endcase
        if (m_ssd && ph != 0) m_pend = 1;
        if (m_sv != '0 && mq.size() == DEPTH && !pop) begin
            m_ovf = 1;
        end else begin
            if (pop) void'(mq.pop_front());
            if (m_sv != '0) mq.push_back('{v: rev(m_sv), d: m_sd});
        end
        m_sv = in_valid; m_sd = in_data; m_ssd = in_set_done;
    endtask

    initial begin
        model_clear();
        forever begin
            @(posedge clk or posedge res);
            if (res) model_clear();
            else model_step();
        end
    end

    // Monitor: compare everything the DUT presents against the model's expected head
    initial begin
        forever begin
            @(negedge clk);
            chk("out_valid", 32'(out_valid), (mq.size() > 0) ? 32'(mq[0].v) : 32'h0);
            chk("out_data", 32'(out_data), (mq.size() > 0) ? 32'(mq[0].d) : 32'h0);
            chk("out_fl_res", 32'(out_fl_res), 32'(m_phase == 3));
            chk("out_busy", 32'(out_busy), 32'(m_phase != 0 || mq.size() > 0 || m_sv != '0));
            chk("out_overflow", 32'(out_overflow), 32'(m_ovf));
            chk("out_beat_count", 32'(out_beat_count), PERF ? 32'(m_beats) : 32'h0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        res = 1'b1; in_valid = '0; in_data = '0; in_set_done = 1'b0; out_ready = 1'b0;
        tick(); tick();
        res = 1'b0;
    endtask

    task automatic drive(input logic [NK-1:0] v, input logic [DW-1:0] d);
        in_valid = v; in_data = d;
        tick();
        in_valid = '0;
    endtask

    task automatic count_pulses(input int cycles, output int pulses);
        pulses = 0;
        for (int i = 0; i < cycles; i++) begin
            if (out_fl_res) pulses++;
            tick();
        end
    endtask

    int pulses;
    bit seen;

    initial begin
        do_reset();
        chk("reset_valid", 32'(out_valid), 32'h0);
        chk("reset_flags", {29'd0, out_fl_res, out_busy, out_overflow}, 32'h0);

        // Single beat with reversed valid, two-edge latency
        out_ready = 1'b1;
        drive(8'b0000_0001, 16'h1234);
        tick();
        chk("single_valid", 32'(out_valid), 32'h80);
        chk("single_data", 32'(out_data), 32'h1234);
        tick();
        chk("single_gone", 32'(out_valid), 32'h0);

        // Five beats into a stalled FIFO: fifth dropped
        do_reset();
        for (int i = 0; i < 5; i++) drive(8'(1 << i), 16'(16'hA000 + i));
        tick(); tick();
        chk("ovf_set", 32'(out_overflow), 32'h1);
        chk("ovf_head", 32'(out_valid), 32'h80);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("ovf_order", 32'(out_data), 32'(16'hA000 + i));
            tick();
        end
        chk("ovf_fifth_absent", 32'(out_valid), 32'h0);

        // Full FIFO with simultaneous push and pop
        do_reset();
        for (int i = 0; i < 14; i++) begin
            if (i == 5) out_ready = 1'b1;
            drive(8'($urandom_range(1, 255)), 16'(16'hB000 + i));
        end
        for (int i = 0; i < 8; i++) tick();
        chk("steady_no_ovf", 32'(out_overflow), 32'h0);

        // set_done with two queued beats: drain then a single pulse
        do_reset();
        drive(8'h03, 16'h1111);
        drive(8'h0C, 16'h2222);
        in_set_done = 1'b1; tick(); in_set_done = 1'b0;
        out_ready = 1'b1;
        count_pulses(60, pulses);
        chk("drain_pulses", 32'(pulses), 32'd1);
        chk("drain_idle", 32'(out_busy), 32'h0);

        // set_done during COUNT yields a second pulse
        do_reset();
        out_ready = 1'b1;
        in_set_done = 1'b1; tick(); in_set_done = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        in_set_done = 1'b1; tick(); in_set_done = 1'b0;
        count_pulses(90, pulses);
        chk("pending_pulses", 32'(pulses), 32'd2);

        // Reset mid-COUNT: everything clears at once and no pulse follows
        do_reset();
        in_set_done = 1'b1; tick(); in_set_done = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        chk("count_busy", 32'(out_busy), 32'h1);
        res = 1'b1;
        #1;
        chk("midreset_outs", {out_valid, out_data, out_beat_count}, 32'h0);
        chk("midreset_flags", {29'd0, out_fl_res, out_busy, out_overflow}, 32'h0);
        tick(); tick();
        res = 1'b0;
        count_pulses(40, pulses);
        chk("midreset_no_pulse", 32'(pulses), 32'd0);

        // Beat counter: 3 pops, then clear after the pulse
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) drive(8'h01, 16'(i));
        tick(); tick();
        chk("perf_three", 32'(out_beat_count), PERF ? 32'd3 : 32'd0);
        in_set_done = 1'b1; tick(); in_set_done = 1'b0;
        seen = 0;
        for (int i = 0; i < 60 && !seen; i++) begin
            if (out_fl_res) seen = 1;
            tick();
        end
        chk("perf_pulse_seen", 32'(seen), 32'h1);
        chk("perf_cleared", 32'(out_beat_count), 32'h0);

        // Randomised traffic with occasional set_done
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            in_valid    = ($urandom_range(0, 1) == 1) ? 8'($urandom) : '0;
            in_data     = 16'($urandom);
            in_set_done = ($urandom_range(0, 63) == 0);
            if (i % 200 == 0) out_ready = $urandom_range(0, 1) == 1;
            else if ($urandom_range(0, 7) == 0) out_ready = ~out_ready;
            tick();
        end
        in_valid = '0; in_set_done = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 100; i++) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
